// File: rtl/hart_mem_pkg.sv
// Shared types and constants for the hart instruction/data memory arbiter.
// Default widths here must match the ADDR_W/DATA_W the arbiter is built with.
package hart_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    localparam logic [MEM_BE_W-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/hart_mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// HART_MEM_ARB_RR_EN selects round-robin on contention; otherwise data always wins.
module hart_mem_arb_pick
    import hart_mem_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef HART_MEM_ARB_RR_EN
    input  owner_e rr_last,
`endif
    output logic   any_req,
    output owner_e winner
);

    assign any_req = i_req | d_req;

    always_comb begin
        winner = DATA;
        if (i_req && d_req) begin
`ifdef HART_MEM_ARB_RR_EN
            winner = (rr_last == DATA) ? FETCH : DATA;
`else
            winner = DATA;
`endif
        end else if (i_req) begin
            winner = FETCH;
        end
    end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares one single-ported memory bus between hart fetch and data ports, one access in flight.
// Build option HART_MEM_ARB_RR_EN: round-robin arbitration instead of fixed data priority.
//
// state | meaning
// IDLE  | no access in flight; grants the winning requester combinationally
// REQ   | m_req driven with latched payload, waiting for m_gnt
// WAIT  | memory accepted, waiting for m_rvalid
module hart_mem_arbiter
    import hart_mem_pkg::*;
#(
    parameter  int ADDR_W      = MEM_ADDR_W,
    parameter  int DATA_W      = MEM_DATA_W,
    parameter  int TIMEOUT_CYC = 255,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              m_req,
    output logic              m_we,
    output logic [BE_W-1:0]   m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);
    localparam logic TMO_EN = (TIMEOUT_CYC != 0);

    arb_state_e       state;
    owner_e           owner;
    owner_e           winner;
    mem_req_t         payload;
    logic [CNT_W-1:0] tmo_cnt;

    logic any_req;
    logic grant;
    logic busy;
    logic done;
    logic tmo_hit;
    logic resp;

`ifdef HART_MEM_ARB_RR_EN
    owner_e rr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= DATA;
        end else if (grant) begin
            rr_last <= winner;
        end
    end
`endif

    hart_mem_arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
`ifdef HART_MEM_ARB_RR_EN
        .rr_last (rr_last),
`endif
        .any_req (any_req),
        .winner  (winner)
    );

    // Grant is gated by rst_n so a held request cannot be granted while reset is asserted.
    assign grant   = rst_n && (state == IDLE) && any_req;
    assign busy    = (state == REQ) || (state == WAIT);
    assign done    = m_rvalid && ((state == WAIT) || ((state == REQ) && m_gnt));
    assign tmo_hit = TMO_EN && busy && (tmo_cnt == CNT_TMO) && !done;
    assign resp    = done || tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= FETCH;
            payload <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state   <= REQ;
                        owner   <= winner;
                        tmo_cnt <= '0;
                        if (winner == DATA) begin
                            payload.we    <= d_we;
                            payload.be    <= d_be;
                            payload.addr  <= d_addr;
                            payload.wdata <= d_wdata;
                        end else begin
                            payload.we    <= 1'b0;
                            payload.be    <= BE_ALL;
                            payload.addr  <= i_addr;
                            payload.wdata <= '0;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (resp) begin
                        state <= IDLE;
                    end else if ((state == REQ) && m_gnt) begin
                        state <= WAIT;
                    end
                    if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_gnt    = grant && (winner == FETCH);
    assign d_gnt    = grant && (winner == DATA);

    assign i_rvalid = resp && (owner == FETCH);
    assign i_err    = tmo_hit && (owner == FETCH);
    assign i_rdata  = (done && (owner == FETCH)) ? m_rdata : '0;

    assign d_rvalid = resp && (owner == DATA);
    assign d_err    = tmo_hit && (owner == DATA);
    assign d_rdata  = (done && (owner == DATA)) ? m_rdata : '0;

    // m_req falls in the timeout cycle itself so the bus is released with the error pulse.
    assign m_req    = (state == REQ) && !tmo_hit;
    assign m_we     = payload.we;
    assign m_be     = payload.be;
    assign m_addr   = payload.addr;
    assign m_wdata  = payload.wdata;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Self-checking bench for hart_mem_arbiter: directed vector table, corner sequences,
// then random traffic against a transaction-level reference model.
module tb_hart_mem_arbiter;

    localparam int TMO = 4;
`ifdef HART_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    hart_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked as busy/accepted/age.
    bit          mb_busy, mb_acc, mb_own, mb_rr;
    int          mb_age;
    logic        mb_we;
    logic [3:0]  mb_be;
    logic [31:0] mb_addr, mb_wdata;
    bit          last_ig, last_dg;

    task automatic model_reset();
        mb_busy = 1'b0; mb_acc = 1'b0; mb_own = 1'b0; mb_age = 0; mb_rr = 1'b1;
        mb_we = 1'b0; mb_be = 4'h0; mb_addr = 32'h0; mb_wdata = 32'h0;
        last_ig = 1'b0; last_dg = 1'b0;
    endtask

    // Called at the negedge: compare DUT against the model, then advance the model.
    task automatic model_cycle();
        bit pick_d, done, tmo, resp;
        bit e_ig, e_dg, e_ir, e_dr, e_ie, e_de, e_mreq;
        logic [31:0] e_rd;
        pick_d = 1'b0; done = 1'b0; tmo = 1'b0; resp = 1'b0;
        e_ig = 1'b0; e_dg = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_ie = 1'b0; e_de = 1'b0;
        e_mreq = 1'b0; e_rd = 32'h0;
        if (!mb_busy) begin
            pick_d = (i_req && d_req) ? (RR ? (mb_rr == 1'b0) : 1'b1) : d_req;
            e_ig = i_req && !pick_d;
            e_dg = d_req && pick_d;
        end else begin
            done   = m_rvalid && (mb_acc || m_gnt);
            tmo    = (mb_age >= TMO) && !done;
            resp   = done || tmo;
            e_mreq = !mb_acc && !tmo;
            e_ir   = resp && !mb_own;
            e_dr   = resp && mb_own;
            e_ie   = tmo && !mb_own;
            e_de   = tmo && mb_own;
            if (done) e_rd = m_rdata;
        end
        chk("model_handshake", 96'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_req}),
            96'({e_ig, e_dg, e_ir, e_dr, e_ie, e_de, e_mreq}));
        chk("model_i_rdata", 96'(i_rdata), 96'(e_ir ? e_rd : 32'h0));
        chk("model_d_rdata", 96'(d_rdata), 96'(e_dr ? e_rd : 32'h0));
        if (e_mreq)
            chk("model_payload", 96'({m_we, m_be, m_addr, m_wdata}),
                96'({mb_we, mb_be, mb_addr, mb_wdata}));
        if (!mb_busy) begin
            if (e_ig || e_dg) begin
                mb_busy = 1'b1; mb_acc = 1'b0; mb_age = 0; mb_own = e_dg; mb_rr = e_dg;
                if (e_dg) {mb_we, mb_be, mb_addr, mb_wdata} = {d_we, d_be, d_addr, d_wdata};
                else      {mb_we, mb_be, mb_addr, mb_wdata} = {1'b0, 4'hF, i_addr, 32'h0};
            end
        end else if (resp) begin
            mb_busy = 1'b0;
        end else begin
            if (m_gnt) mb_acc = 1'b1;
            mb_age++;
        end
        last_ig = e_ig;
        last_dg = e_dg;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dwe;
        logic [3:0]  dbe;
        logic [31:0] da, dwd;
        logic        mg, mv;
        logic [31:0] md;
        logic [6:0]  e_hs;   // {i_gnt,d_gnt,i_rvalid,d_rvalid,i_err,d_err,m_req}
        logic [31:0] e_rd;
        logic [31:0] e_ma;
        logic [3:0]  e_mbe;
        logic        e_mwe;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        7'b1000000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,        7'b0000001, 32'h0,        32'h100, 4'hF, 1'b0};
        vecs[2]  = '{1'b0, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        7'b0000000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 7'b0010000, 32'hDEADBEEF, 32'h0,   4'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        7'b0000000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h300, 1'b1, 1'b1, 4'h3, 32'h200, 32'hCAFE, 1'b0, 1'b0, 32'h0,   7'b0100000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h300, 1'b0, 1'b1, 4'h3, 32'h200, 32'hCAFE, 1'b1, 1'b0, 32'h0,   7'b0000001, 32'h0,        32'h200, 4'h3, 1'b1};
        vecs[7]  = '{1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55,       7'b0001000, 32'h55,       32'h0,   4'h0, 1'b0};
        vecs[8]  = '{1'b1, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        7'b1000000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b1, 1'b1, 32'h11111111, 7'b0010001, 32'h11111111, 32'h300, 4'hF, 1'b0};
        vecs[10] = '{1'b0, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0,      7'b0100000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h300, 1'b0, 1'b0, 4'hF, 32'h400, 32'h0, 1'b1, 1'b1, 32'h12345678, 7'b0001001, 32'h12345678, 32'h400, 4'hF, 1'b0};
        vecs[12] = '{1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        7'b1000000, 32'h0,        32'h0,   4'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hA5A5A5A5, 7'b0010001, 32'hA5A5A5A5, 32'h104, 4'hF, 1'b0};
        vecs[14] = '{1'b0, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        7'b0000000, 32'h0,        32'h0,   4'h0, 1'b0};

        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        model_reset();
        #12;
        chk("reset_handshake", 96'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_req}), 96'(0));
        chk("reset_payload", 96'({m_we, m_be, m_addr, m_wdata}), 96'(0));
        chk("reset_rdata", 96'({i_rdata, d_rdata}), 96'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table: fetch-only, contention, same-cycle gnt+rvalid, back-to-back.
        for (int k = 0; k < 15; k++) begin
            i_req = vecs[k].ir; i_addr = vecs[k].ia;
            d_req = vecs[k].dr; d_we = vecs[k].dwe; d_be = vecs[k].dbe;
            d_addr = vecs[k].da; d_wdata = vecs[k].dwd;
            m_gnt = vecs[k].mg; m_rvalid = vecs[k].mv; m_rdata = vecs[k].md;
            @(negedge clk);
            chk($sformatf("tbl%0d_handshake", k),
                96'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_req}), 96'(vecs[k].e_hs));
            chk($sformatf("tbl%0d_i_rdata", k), 96'(i_rdata),
                96'(vecs[k].e_hs[4] ? vecs[k].e_rd : 32'h0));
            chk($sformatf("tbl%0d_d_rdata", k), 96'(d_rdata),
                96'(vecs[k].e_hs[3] ? vecs[k].e_rd : 32'h0));
            if (vecs[k].e_hs[0])
                chk($sformatf("tbl%0d_m_payload", k), 96'({m_we, m_be, m_addr}),
                    96'({vecs[k].e_mwe, vecs[k].e_mbe, vecs[k].e_ma}));
            model_cycle();
            @(posedge clk);
            #1;
        end
        i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;

        // Timeout: data load, memory never grants.
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500; d_wdata = 32'h0;
        @(negedge clk);
        chk("tmo_grant", 96'({i_gnt, d_gnt}), 96'(2'b01));
        model_cycle();
        @(posedge clk);
        #1;
        d_req = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_mreq_c%0d", k), 96'({m_req, d_rvalid}), 96'(2'b10));
            model_cycle();
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tmo_err_pulse", 96'({d_rvalid, d_err, m_req, i_rvalid}), 96'(4'b1100));
        chk("tmo_rdata", 96'(d_rdata), 96'(0));
        model_cycle();
        @(posedge clk);
        #1;
        m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("tmo_stray_rvalid", 96'({i_rvalid, d_rvalid, d_err, m_req}), 96'(0));
        model_cycle();
        @(posedge clk);
        #1;
        m_rvalid = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;

        // Reset while WAIT: async drop, then stale response ignored.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        tick();
        d_req = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0; i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 96'({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}), 96'(0));
        model_reset();
        @(posedge clk);
        #1;
        i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BADF00D;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stale_rvalid", 96'({i_rvalid, d_rvalid, m_req, i_gnt, d_gnt}), 96'(0));
        model_cycle();
        @(posedge clk);
        #1;
        m_rvalid = 1'b0;
        i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1; d_addr = 32'h800;
        @(negedge clk);
        chk("post_reset_pick", 96'({i_gnt, d_gnt}), 96'(RR ? 2'b10 : 2'b01));
        model_cycle();
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (i_req && (last_ig || $urandom_range(15) == 0)) i_req = 1'b0;
            if (!i_req && $urandom_range(2) == 0) begin
                i_req  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req && (last_dg || $urandom_range(15) == 0)) d_req = 1'b0;
            if (!d_req && $urandom_range(2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(1));
                d_be    = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            m_gnt    = ($urandom_range(2) == 0);
            m_rvalid = ($urandom_range(3) == 0);
            m_rdata  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
